mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the core's instruction-fetch requester and its load/store requester.
- Arbitrates with round-robin on ties and allows one outstanding transaction at a time.
- Sequences a req/ready handshake to a variable-latency memory, returns read data with a one-cycle ack pulse, and drives a stall to the core while any request is unserved.
- Includes a watchdog that terminates hung memory transactions with an error.

Parameters:
- TIMEOUT, 16, max BUSY cycles before forced abort; 0 disables watchdog.
- ERR_DATA, 32'h0000_0000, read data returned on an aborted transaction.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- if_req  input  1  fetch request; held with if_addr stable until if_ack.
- if_addr  input  32  fetch address.
- if_rdata  output  32  fetched word; valid while if_ack=1.
- if_ack  output  1  one-cycle completion pulse, fetch.
- d_req  input  1  data request; held with payload stable until d_ack.
- d_we  input  1  1=store, 0=load.
- d_addr  input  32  data address.
- d_wdata  input  32  store data.
- d_wstrb  input  4  store byte enables.
- d_rdata  output  32  load word; valid while d_ack=1.
- d_ack  output  1  one-cycle completion pulse, data.
- mem_req  output  1  memory request; held until mem_ready or abort.
- mem_we  output  1  memory write enable.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_wstrb  output  4  memory byte enables.
- mem_rdata  input  32  memory read data; valid with mem_ready.
- mem_ready  input  1  memory completion, one cycle.
- stall  output  1  core stall.
- err  output  1  one-cycle pulse on watchdog abort.
- err_src  output  1  owner of aborted transaction: 0=fetch, 1=data; valid with err.

Behaviour:
- Reset:
  - State=IDLE, last_grant=fetch.
  - All outputs 0, timeout counter 0.
  - A reset mid-transaction drops mem_req the next cycle and discards the transaction.
  - A late mem_ready after reset is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Samples if_req and d_req.
  - Only one asserted: grant it.
  - Both asserted: grant the one that is not last_grant (first tie after reset goes to data).
  - On grant, register owner, address, we, wdata and wstrb into the mem_* outputs, set mem_req=1, update last_grant, go to BUSY.
  - Fetch grant drives mem_we=0, mem_wstrb=0, mem_wdata=0.
  - No request: stay in IDLE, mem_req=0.
- BUSY:
  - mem_* outputs held constant; counter increments each cycle.
  - mem_ready=1: capture mem_rdata into the owner's rdata register, assert the owner's ack for the next cycle, mem_req=0, go to DONE.
  - TIMEOUT!=0, counter reaches TIMEOUT and no mem_ready that cycle: mem_req=0, owner's rdata=ERR_DATA, owner's ack=1, err=1, err_src=owner, go to DONE.
  - mem_ready in the same cycle as expiry: normal completion wins, no err.
- DONE:
  - Ack (and err, if aborted) high for exactly this cycle.
  - No grant is made in DONE, so a requester still holding req here is not re-served.
  - Go to IDLE; counter cleared.
- Latency: req sampled in IDLE at cycle N; mem_req high N+1; mem_ready at earliest N+1; ack at N+2; next grant at N+3 at the earliest.
- mem_ready while in IDLE or DONE: ignored.
- rdata registers hold their last value outside ack cycles.
- Stores: the owner's rdata is loaded with mem_rdata regardless, and the requester ignores it.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
- A requester deasserting req before its ack is a protocol violation; the transaction still completes and acks.

Test Plan:
- Fetch alone: if_req=1, if_addr=0x100, mem_ready one cycle after mem_req with rdata=0x00500093 -> mem_addr=0x100, mem_we=0, if_ack pulse exactly 2 cycles after sample with if_rdata=0x00500093, stall low from the ack cycle onward.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xCAFEF00D, d_wstrb=4'b0011 -> mem_* mirror these values while mem_req is high; d_ack pulses once; mem_req held across a 5-cycle mem_ready delay.
- Tie after reset: if_req and d_req asserted together -> data served first, fetch second. Then assert both again -> data granted first again, since last_grant is now fetch. Verify alternation over 4 consecutive ties.
- Timeout: TIMEOUT=4, d_req load, mem_ready never asserted -> mem_req drops after 4 BUSY cycles, d_ack=1 with d_rdata=ERR_DATA, err=1 and err_src=1 in the same cycle. Repeat with mem_ready on the expiry cycle -> no err, real data returned.
- Reset mid-BUSY: assert rst with mem_req=1 -> next cycle all outputs 0, state IDLE. Then apply mem_ready -> no ack. A new fetch afterwards completes normally.
- Held req across DONE: requester keeps if_req high through the ack cycle -> no second mem_req until IDLE, then exactly one new transaction.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one single-ported memory
// Round-robin on ties, one outstanding transaction, watchdog abort on hung memory.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall,
   output logic        err,
   output logic        err_src
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state, state_next;
   logic          owner;        // 0 = fetch, 1 = data
   logic          last_grant;
   logic          grant;
   logic          grant_d;
   logic          complete;
   logic          expire;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_d    = 1'b0;
      complete   = 1'b0;
      expire     = 1'b0;
      case (state)
         IDLE: begin
            if (if_req | d_req) begin
               grant      = 1'b1;
               // on a tie, data wins unless data was the last one served
               grant_d    = d_req & (~if_req | ~last_grant);
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               complete   = 1'b1;
               state_next = DONE;
            end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
               expire     = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= 1'b0;
         last_grant <= 1'b0;
         cnt        <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         if_ack     <= 1'b0;
         d_ack      <= 1'b0;
         err        <= 1'b0;
         err_src    <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         err    <= 1'b0;
         if (grant) begin
            owner      <= grant_d;
            last_grant <= grant_d;
            cnt        <= '0;
            mem_req    <= 1'b1;
            mem_we     <= grant_d & d_we;
            mem_addr   <= grant_d ? d_addr  : if_addr;
            mem_wdata  <= grant_d ? d_wdata : 32'h0;
            mem_wstrb  <= grant_d ? d_wstrb : 4'h0;
         end
         if (state == BUSY) cnt <= cnt + CW'(1);
         if (state == DONE) cnt <= '0;
         if (complete || expire) begin
            mem_req <= 1'b0;
            if (owner) begin
               d_rdata <= complete ? mem_rdata : ERR_DATA;
               d_ack   <= 1'b1;
            end else begin
               if_rdata <= complete ? mem_rdata : ERR_DATA;
               if_ack   <= 1'b1;
            end
            if (expire) begin
               err     <= 1'b1;
               err_src <= owner;
            end
         end
      end
   end

   assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed-vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_ack, d_ack, mem_req, mem_we, stall, err, err_src;
   logic [3:0]  mem_wstrb;

   logic [31:0] if_rdata_t, d_rdata_t, mem_addr_t, mem_wdata_t;
   logic        if_ack_t, d_ack_t, mem_req_t, mem_we_t, stall_t, err_t, err_src_t;
   logic [3:0]  mem_wstrb_t;

   int nvec = 0;
   int nmis = 0;

   mem_port_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall(stall), .err(err), .err_src(err_src)
   );

   mem_port_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut_t (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_t), .if_ack(if_ack_t),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata_t), .d_ack(d_ack_t),
      .mem_req(mem_req_t), .mem_we(mem_we_t), .mem_addr(mem_addr_t),
      .mem_wdata(mem_wdata_t), .mem_wstrb(mem_wstrb_t),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall(stall_t), .err(err_t), .err_src(err_src_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // One transaction on the main instance; requests are left as the caller set them.
   task automatic do_txn(input bit dsel, input logic [31:0] rd);
      tick();
      check("txn_req", mem_req, 1);
      check("txn_addr", mem_addr, dsel ? d_addr : if_addr);
      mem_ready = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ready = 1'b0;
      check("txn_if_ack", if_ack, !dsel);
      check("txn_d_ack", d_ack, dsel);
      check("txn_rdata", dsel ? d_rdata : if_rdata, rd);
      check("txn_done_no_req", mem_req, 0);
      tick();
      check("txn_idle_no_req", mem_req, 0);
      check("txn_ack_clear", if_ack | d_ack, 0);
   endtask

   initial begin
      rst = 1'b1;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
      d_wdata = 0; d_wstrb = 0; mem_rdata = 0; mem_ready = 0;
      tick();
      tick();
      check("rst_mem_req", mem_req, 0);
      check("rst_acks", {if_ack, d_ack, err, err_src}, 0);
      check("rst_stall", stall, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_if_rdata", if_rdata, 0);
      rst = 1'b0;

      // fetch alone
      if_req = 1; if_addr = 32'h100;
      #1 check("f_stall_wait", stall, 1);
      tick();
      check("f_mem_req", mem_req, 1);
      check("f_mem_addr", mem_addr, 32'h100);
      check("f_mem_we", mem_we, 0);
      check("f_mem_wstrb", mem_wstrb, 0);
      check("f_ack_early", if_ack, 0);
      mem_ready = 1; mem_rdata = 32'h0050_0093;
      tick();
      mem_ready = 0;
      check("f_ack", if_ack, 1);
      check("f_rdata", if_rdata, 32'h0050_0093);
      check("f_stall_ack", stall, 0);
      check("f_req_drop", mem_req, 0);
      if_req = 0;
      tick();
      check("f_ack_pulse", if_ack, 0);
      check("f_rdata_hold", if_rdata, 32'h0050_0093);
      check("f_stall_after", stall, 0);

      // store with 5 idle BUSY cycles before mem_ready
      d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'b0011;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("s_mem_req", mem_req, 1);
         check("s_mem_we", mem_we, 1);
         check("s_mem_addr", mem_addr, 32'h2000);
         check("s_mem_wdata", mem_wdata, 32'hCAFE_F00D);
         check("s_mem_wstrb", mem_wstrb, 4'b0011);
         check("s_no_ack", d_ack, 0);
         check("s_stall", stall, 1);
         tick();
      end
      mem_ready = 1; mem_rdata = 32'h1111_2222;
      tick();
      mem_ready = 0;
      check("s_ack", d_ack, 1);
      check("s_rdata", d_rdata, 32'h1111_2222);
      check("s_no_err", err, 0);
      d_req = 0; d_we = 0;
      tick();
      check("s_ack_pulse", d_ack, 0);

      // ties after reset: data first, then alternate while both stay held
      do_reset();
      if_addr = 32'h300; d_addr = 32'h400; d_we = 0;
      if_req = 1; d_req = 1;
      do_txn(1, 32'hD000_0001);
      do_txn(0, 32'hF000_0001);
      do_txn(1, 32'hD000_0002);
      do_txn(0, 32'hF000_0002);
      if_req = 0; d_req = 0;
      tick();
      if_req = 1; d_req = 1;
      do_txn(1, 32'hD000_0003);
      d_req = 0;
      do_txn(0, 32'hF000_0003);
      if_req = 0;

      // watchdog abort on the TIMEOUT=4 instance
      do_reset();
      d_req = 1; d_we = 0; d_addr = 32'h500;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("to_busy_req", mem_req_t, 1);
         check("to_busy_ack", d_ack_t, 0);
      end
      tick();
      check("to_req_drop", mem_req_t, 0);
      check("to_ack", d_ack_t, 1);
      check("to_rdata", d_rdata_t, 32'hDEAD_BEEF);
      check("to_err", err_t, 1);
      check("to_err_src", err_src_t, 1);
      d_req = 0;
      tick();
      check("to_err_pulse", err_t, 0);

      // mem_ready on the expiry cycle: normal completion wins
      d_req = 1; d_addr = 32'h504;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("tr_busy_req", mem_req_t, 1);
      end
      mem_ready = 1; mem_rdata = 32'h1234_5678;
      tick();
      mem_ready = 0;
      check("tr_ack", d_ack_t, 1);
      check("tr_rdata", d_rdata_t, 32'h1234_5678);
      check("tr_no_err", err_t, 0);
      d_req = 0;
      tick();

      // reset in the middle of a transaction
      do_reset();
      if_req = 1; if_addr = 32'h700;
      tick();
      check("rb_mem_req", mem_req, 1);
      rst = 1; if_req = 0;
      tick();
      rst = 0;
      check("rb_mem_req_drop", mem_req, 0);
      check("rb_mem_addr", mem_addr, 0);
      check("rb_stall", stall, 0);
      mem_ready = 1; mem_rdata = 32'h0000_FFFF;
      tick();
      mem_ready = 0;
      check("rb_late_ack", {if_ack, d_ack}, 0);
      check("rb_late_rdata", if_rdata, 0);
      check("rb_late_req", mem_req, 0);
      if_req = 1; if_addr = 32'h800;
      do_txn(0, 32'hA5A5_A5A5);
      if_req = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
